exp_row_align: RTL and testbench
================================

EXP_ROW_ALIGN -- requirements
Module: exp_row_align

Interface
REQ-001 Parameters (name, default, meaning): MAT_SIZE_1, 16, rows per matrix; MAT_SIZE_2, 16, columns per row; FP_EXP_W, 8, raw exponent width; SHIFT_W, 5, alignment-shift width; ROW_IDX_W, $clog2(MAT_SIZE_1) (min 1), row index width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, async active-high reset
- in_valid, in, 1, matrix offered
- in_ready, out, 1, block can accept a matrix
- in_exp_matrix, in, FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2, raw exponent matrix; element (i,j) at index i*MAT_SIZE_2+j, LSB-first, same packing as the exponent cross-product stage output
- out_valid, out, 1, row result valid
- out_ready, in, 1, downstream accepts row
- out_row_idx, out, ROW_IDX_W, row index of current result
- out_row_max, out, FP_EXP_W, maximum raw exponent in row
- out_shift, out, SHIFT_W*MAT_SIZE_2, per-column right-shift amount, column j at [(j+1)*SHIFT_W-1 -: SHIFT_W]
- out_zero_mask, out, MAT_SIZE_2, 1 = element raw exponent is 0 (zero or flushed)
- out_last, out, 1, current row is row MAT_SIZE_1-1

Function
REQ-004 FSM states: IDLE, LOAD, EMIT; the encoding is implementation choice.
REQ-005 in_ready SHALL be 1 only in IDLE while rst is low.
REQ-006 On a clock edge with in_valid && in_ready: in_exp_matrix is captured into an internal matrix register, row_ptr <= 0, state -> LOAD.
REQ-007 In LOAD: on the next edge, row 0 results are registered onto the outputs, out_valid <= 1, state -> EMIT. First-row latency is 2 edges after acceptance.
REQ-008 Row result for row r: out_row_max = unsigned max of the MAT_SIZE_2 raw exponents; for each column j, if e==0 then out_zero_mask[j]=1 and shift = SHIFT_MAX = 2^SHIFT_W-1; otherwise shift = min(out_row_max - e, SHIFT_MAX) and mask=0.
REQ-009 Subtraction SHALL be unsigned, FP_EXP_W bits wide, non-negative by construction; clipping compares the full FP_EXP_W-bit difference against SHIFT_MAX.
REQ-010 For an all-zero row: out_row_max=0, mask all 1s, all shifts SHIFT_MAX.
REQ-011 In EMIT, all outputs SHALL hold stable while out_valid && !out_ready.
REQ-012 In EMIT, on out_valid && out_ready with row_ptr < MAT_SIZE_1-1: the next row's results are registered on the same edge, row_ptr increments, out_valid stays 1 (1 row/cycle throughput).
REQ-013 In EMIT, on out_valid && out_ready with out_last=1: out_valid <= 0, state -> IDLE; in_ready is 1 on the following cycle (no same-cycle accept while emitting).
REQ-014 out_row_idx SHALL equal row_ptr for the row being presented; out_last = (out_row_idx == MAT_SIZE_1-1).
REQ-015 in_exp_matrix changes outside an accepting edge SHALL have no effect on the results.
REQ-016 With MAT_SIZE_1=1, LOAD -> EMIT presents a single row with out_last=1.

Reset
REQ-017 While rst=1, asynchronously: state=IDLE, row_ptr=0, out_valid=0, out_row_idx=0, out_row_max=0, out_shift=0, out_zero_mask=0, out_last=0, and the matrix register is cleared.
REQ-018 Reset asserted mid-matrix SHALL abandon the matrix; after release, in_ready=1 and no stale row is emitted.

Verification
REQ-019 Defaults; row 0 exponents {127,130,120,0,127,...(rest 127)}, out_ready=1 -> row 0: max=130, shifts {3,0,10,31,3,...}, mask bit3=1, out_valid 2 edges after accept.
REQ-020 Row with exponents 200 and 10 -> shift for 10 clipped to 31; row all 0 -> max=0, mask=16'hFFFF, all shifts 31.
REQ-021 out_ready held low 5 cycles on row 3 -> outputs stable, out_row_idx=3; then 16 rows total delivered in order, out_last only on row 15.
REQ-022 Back-to-back matrices with in_valid held high -> second accept occurs exactly 1 cycle after the row-15 handshake; in_ready=0 throughout EMIT.
REQ-023 rst pulsed during row 7 -> all outputs zero immediately, in_ready=1 after release, next matrix starts at out_row_idx=0.
REQ-024 MAT_SIZE_1=1, MAT_SIZE_2=4 -> single row with out_last=1, then IDLE.

Source files
------------

// File: rtl/exp_row_align.sv
// Per-row exponent alignment: captures an exponent matrix, then emits one row
// per cycle with the row maximum, clipped right-shift amounts and a zero mask.
module exp_row_align #(
  parameter int MAT_SIZE_1 = 16,
  parameter int MAT_SIZE_2 = 16,
  parameter int FP_EXP_W   = 8,
  parameter int SHIFT_W    = 5,
  parameter int ROW_IDX_W  = (MAT_SIZE_1 > 1) ? $clog2(MAT_SIZE_1) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2-1:0] in_exp_matrix,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ROW_IDX_W-1:0]                    out_row_idx,
  output logic [FP_EXP_W-1:0]                     out_row_max,
  output logic [SHIFT_W*MAT_SIZE_2-1:0]           out_shift,
  output logic [MAT_SIZE_2-1:0]                   out_zero_mask,
  output logic                                    out_last
);

  localparam int MAT_W = FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = '1;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(MAT_SIZE_1-1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  state_t state_q, state_d;

  logic [MAT_W-1:0]             mat_q;
  logic [ROW_IDX_W-1:0]         row_ptr;
  logic [ROW_IDX_W-1:0]         sel_row;
  logic [FP_EXP_W-1:0]          row_max;
  logic [SHIFT_W*MAT_SIZE_2-1:0] row_shift;
  logic [MAT_SIZE_2-1:0]        row_zero;
  logic [FP_EXP_W-1:0]          elem;
  logic [FP_EXP_W-1:0]          diff;
  logic                         accept;
  logic                         hs;
  logic                         advance;
  logic                         finish;
  int                           base;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign hs          = (state_q == EMIT) && out_valid && out_ready;
  assign advance     = hs && !out_last;
  assign finish      = hs && out_last;
  assign out_row_idx = row_ptr;

  // LOAD presents the current pointer (0); EMIT looks one row ahead
  always_comb begin
    sel_row = row_ptr;
    if (state_q == EMIT) sel_row = row_ptr + 1'b1;
    if (int'(sel_row) >= MAT_SIZE_1) sel_row = '0;
  end

  always_comb begin
    row_max   = '0;
    row_shift = '0;
    row_zero  = '0;
    elem      = '0;
    diff      = '0;
    base      = int'(sel_row) * MAT_SIZE_2;
    for (int j = 0; j < MAT_SIZE_2; j++) begin
      elem = mat_q[(base+j)*FP_EXP_W +: FP_EXP_W];
      if (elem > row_max) row_max = elem;
    end
    for (int j = 0; j < MAT_SIZE_2; j++) begin
      elem = mat_q[(base+j)*FP_EXP_W +: FP_EXP_W];
      diff = row_max - elem;
      if (elem == '0) begin
        row_zero[j] = 1'b1;
        row_shift[j*SHIFT_W +: SHIFT_W] = SHIFT_MAX;
      end else if (32'(diff) > 32'(SHIFT_MAX)) begin
        row_shift[j*SHIFT_W +: SHIFT_W] = SHIFT_MAX;
      end else begin
        row_shift[j*SHIFT_W +: SHIFT_W] = SHIFT_W'(diff);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = EMIT;
      EMIT:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mat_q         <= '0;
      row_ptr       <= '0;
      out_valid     <= 1'b0;
      out_row_max   <= '0;
      out_shift     <= '0;
      out_zero_mask <= '0;
      out_last      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mat_q   <= in_exp_matrix;
        row_ptr <= '0;
      end
      if (state_q == LOAD || advance) begin
        out_valid     <= 1'b1;
        row_ptr       <= sel_row;
        out_row_max   <= row_max;
        out_shift     <= row_shift;
        out_zero_mask <= row_zero;
        out_last      <= (sel_row == LAST_ROW);
      end
      if (finish) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exp_row_align.sv
// Bench for exp_row_align: directed + random matrices against a row model,
// plus a 1x4 instance for the single-row case.
module tb_exp_row_align;

  localparam int M1 = 16;
  localparam int M2 = 16;
  localparam int EW = 8;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  in_valid, in_ready;
  logic [EW*M1*M2-1:0]   in_exp_matrix;
  logic                  out_valid, out_ready;
  logic [3:0]            out_row_idx;
  logic [EW-1:0]         out_row_max;
  logic [SW*M2-1:0]      out_shift;
  logic [M2-1:0]         out_zero_mask;
  logic                  out_last;

  logic                  s_in_valid, s_in_ready;
  logic [31:0]           s_in_exp;
  logic                  s_out_valid, s_out_ready;
  logic [0:0]            s_out_row_idx;
  logic [7:0]            s_out_row_max;
  logic [19:0]           s_out_shift;
  logic [3:0]            s_out_zero_mask;
  logic                  s_out_last;

  exp_row_align dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp_matrix(in_exp_matrix),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row_idx(out_row_idx), .out_row_max(out_row_max),
    .out_shift(out_shift), .out_zero_mask(out_zero_mask),
    .out_last(out_last)
  );

  exp_row_align #(.MAT_SIZE_1(1), .MAT_SIZE_2(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_exp_matrix(s_in_exp),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_row_idx(s_out_row_idx), .out_row_max(s_out_row_max),
    .out_shift(s_out_shift), .out_zero_mask(s_out_zero_mask),
    .out_last(s_out_last)
  );

  int checks = 0;
  int errors = 0;
  int m [M1][M2];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW*M1*M2-1:0] pack();
    logic [EW*M1*M2-1:0] v;
    v = '0;
    for (int i = 0; i < M1; i++)
      for (int j = 0; j < M2; j++)
        v[(i*M2+j)*EW +: EW] = 8'(m[i][j]);
    return v;
  endfunction

  function automatic void fill();
    for (int i = 0; i < M1; i++)
      for (int j = 0; j < M2; j++) begin
        if (i % 3 == 1) m[i][j] = int'($urandom_range(120, 140));
        else if ($urandom_range(0, 7) == 0) m[i][j] = 0;
        else m[i][j] = int'($urandom_range(1, 255));
      end
  endfunction

  // Model: max of row; shift = min(max - e, 31); zero elements force 31
  task automatic ref_row(input int r, output int mx,
                         output logic [SW*M2-1:0] sh,
                         output logic [M2-1:0] mk);
    int d;
    mx = 0;
    sh = '0;
    mk = '0;
    for (int j = 0; j < M2; j++) if (m[r][j] > mx) mx = m[r][j];
    for (int j = 0; j < M2; j++) begin
      d = mx - m[r][j];
      if (m[r][j] == 0) begin
        mk[j] = 1'b1;
        sh[j*SW +: SW] = 5'd31;
      end else begin
        sh[j*SW +: SW] = (d > 31) ? 5'd31 : 5'(d);
      end
    end
  endtask

  task automatic check_row(input int r);
    int mx;
    logic [SW*M2-1:0] sh;
    logic [M2-1:0] mk;
    ref_row(r, mx, sh, mk);
    chk($sformatf("valid r%0d", r), 128'(out_valid), 128'(1));
    chk($sformatf("idx r%0d", r), 128'(out_row_idx), 128'(r));
    chk($sformatf("max r%0d", r), 128'(out_row_max), 128'(mx));
    chk($sformatf("shift r%0d", r), 128'(out_shift), 128'(sh));
    chk($sformatf("mask r%0d", r), 128'(out_zero_mask), 128'(mk));
    chk($sformatf("last r%0d", r), 128'(out_last), 128'(r == M1-1));
    chk($sformatf("in_ready r%0d", r), 128'(in_ready), 128'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " valid"}, 128'(out_valid), 128'(0));
    chk({tag, " idx"}, 128'(out_row_idx), 128'(0));
    chk({tag, " max"}, 128'(out_row_max), 128'(0));
    chk({tag, " shift"}, 128'(out_shift), 128'(0));
    chk({tag, " mask"}, 128'(out_zero_mask), 128'(0));
    chk({tag, " last"}, 128'(out_last), 128'(0));
    chk({tag, " in_ready"}, 128'(in_ready), 128'(0));
  endtask

  initial begin
    int r;
    int cyc;
    logic rdy;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_exp_matrix = '0;
    s_in_valid = 1'b0;
    s_out_ready = 1'b0;
    s_in_exp = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 128'(in_ready), 128'(1));

    // Matrix A: directed rows 0..2, stall on row 3, garbage input after accept
    fill();
    for (int j = 0; j < M2; j++) begin
      m[0][j] = 127;
      m[1][j] = int'($urandom_range(10, 200));
      m[2][j] = 0;
    end
    m[0][1] = 130;
    m[0][2] = 120;
    m[0][3] = 0;
    m[1][0] = 200;
    m[1][5] = 10;
    in_exp_matrix = pack();
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("A lat1 valid", 128'(out_valid), 128'(0));
    chk("A lat1 in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    in_exp_matrix = ~in_exp_matrix;
    tick();
    chk("A row0 max", 128'(out_row_max), 128'(130));
    chk("A row0 shift3", 128'(out_shift[19:15]), 128'(31));
    chk("A row0 shift2", 128'(out_shift[14:10]), 128'(10));
    for (int i = 0; i < M1; i++) begin
      check_row(i);
      if (i == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          check_row(3);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("A done valid", 128'(out_valid), 128'(0));
    chk("A done in_ready", 128'(in_ready), 128'(1));

    // Matrix B then C back-to-back with in_valid held high
    fill();
    in_exp_matrix = pack();
    in_valid = 1'b1;
    tick();
    chk("B lat1 valid", 128'(out_valid), 128'(0));
    tick();
    for (int i = 0; i < M1; i++) begin
      check_row(i);
      if (i == M1-1) begin
        fill();
        in_exp_matrix = pack();
      end
      tick();
    end
    chk("B done in_ready", 128'(in_ready), 128'(1));
    chk("B done valid", 128'(out_valid), 128'(0));
    tick();
    chk("C accepted", 128'(in_ready), 128'(0));
    chk("C lat1 valid", 128'(out_valid), 128'(0));
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      check_row(i);
      tick();
    end
    check_row(7);

    // Reset mid-matrix
    rst = 1'b1;
    #1;
    chk_zero_outs("midrst");
    tick();
    rst = 1'b0;
    #1;
    chk("midrst in_ready", 128'(in_ready), 128'(1));
    repeat (3) begin
      tick();
      chk("no stale row", 128'(out_valid), 128'(0));
    end

    // Matrix D with random backpressure
    fill();
    in_exp_matrix = pack();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    r = 0;
    cyc = 0;
    while (r < M1 && cyc < 400) begin
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      check_row(r);
      tick();
      if (rdy) r++;
      cyc++;
    end
    chk("D rows delivered", 128'(r), 128'(M1));
    chk("D done valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;

    // Single-row 1x4 instance: elements 40,38,0,9
    s_in_exp = {8'd9, 8'd0, 8'd38, 8'd40};
    s_in_valid = 1'b1;
    s_out_ready = 1'b1;
    tick();
    chk("S lat1 valid", 128'(s_out_valid), 128'(0));
    s_in_valid = 1'b0;
    tick();
    chk("S valid", 128'(s_out_valid), 128'(1));
    chk("S last", 128'(s_out_last), 128'(1));
    chk("S idx", 128'(s_out_row_idx), 128'(0));
    chk("S max", 128'(s_out_row_max), 128'(40));
    chk("S shift", 128'(s_out_shift),
        128'({5'd31, 5'd31, 5'd2, 5'd0}));
    chk("S mask", 128'(s_out_zero_mask), 128'(4'b0100));
    tick();
    chk("S done valid", 128'(s_out_valid), 128'(0));
    chk("S done in_ready", 128'(s_in_ready), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
